pipe_ctrl: RTL and testbench

Hazard and stall sequencer for the 16-bit five-stage pipeline. It watches the ID, EX and MEM stages and generates every stall, flush and bubble control for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and for the PC. It resolves load-use hazards, branch mispredicts, instruction-fetch misses, multi-cycle data-memory waits with a timeout, and HALT/resume. It also keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Hazard and stall sequencer for the 16-bit five-stage pipeline: load-use, mispredict, fetch miss,
// data-memory wait with timeout, HALT drain/resume, plus saturating stall/flush counters.
module pipe_ctrl #(
   parameter int unsigned MEM_TO_CYC = 64,
   parameter int unsigned DRAIN_CYC  = 3,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       i_id_p0_addr,
   input  logic [3:0]       i_id_p1_addr,
   input  logic             i_id_p0_used,
   input  logic             i_id_p1_used,
   input  logic             i_id_halt,
   input  logic [3:0]       i_ex_dst_addr,
   input  logic             i_ex_we,
   input  logic             i_ex_mem_re,
   input  logic             i_ex_mispredict,
   input  logic             i_if_rdy,
   input  logic             i_mem_access,
   input  logic             i_mem_rdy,
   input  logic             i_resume,
   output logic             o_stall_if_id,
   output logic             o_stall_id_ex,
   output logic             o_stall_ex_mem,
   output logic             o_flush_if_id,
   output logic             o_flush_id_ex,
   output logic             o_bubble_mem_wb,
   output logic             o_pc_hold,
   output logic             o_pc_redirect,
   output logic             o_halted,
   output logic             o_mem_timeout,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_DRAIN    = 2'd2;
   localparam logic [1:0] ST_HALT     = 2'd3;

   localparam int unsigned         WAIT_W     = $clog2(MEM_TO_CYC);
   localparam int unsigned         DRAIN_W    = $clog2(DRAIN_CYC + 1);
   localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(MEM_TO_CYC - 1);
   localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

   logic [1:0]         r_state;
   logic               r_ret_drain;
   logic [WAIT_W-1:0]  r_wait;
   logic [DRAIN_W-1:0] r_drain;
   logic               r_timeout;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [CNT_W-1:0]   r_flush_cnt;

   logic               w_mw;
   logic               w_lu;
   logic [1:0]         w_eff;
   logic [1:0]         w_state_nxt;
   logic               w_ret_nxt;
   logic [WAIT_W-1:0]  w_wait_nxt;
   logic [DRAIN_W-1:0] w_drain_nxt;
   logic               w_timeout_nxt;

   assign w_mw = i_mem_access & ~i_mem_rdy;
   assign w_lu = i_ex_mem_re & i_ex_we & (i_ex_dst_addr != 4'd0) &
                 ((i_id_p0_used & (i_id_p0_addr == i_ex_dst_addr)) |
                  (i_id_p1_used & (i_id_p1_addr == i_ex_dst_addr)));

   // The cycle that releases a memory wait already behaves as the state being returned to,
   // so a wait during DRAIN stretches the drain by exactly the number of waited cycles.
   assign w_eff = ((r_state == ST_MEM_WAIT) && !w_mw) ? (r_ret_drain ? ST_DRAIN : ST_RUN)
                                                      : r_state;

   always_comb begin
      o_stall_if_id   = 1'b0;
      o_stall_id_ex   = 1'b0;
      o_stall_ex_mem  = 1'b0;
      o_flush_if_id   = 1'b0;
      o_flush_id_ex   = 1'b0;
      o_bubble_mem_wb = 1'b0;
      o_pc_hold       = 1'b0;
      o_pc_redirect   = 1'b0;
      if (r_state == ST_HALT || w_mw) begin
         o_stall_if_id   = 1'b1;
         o_stall_id_ex   = 1'b1;
         o_stall_ex_mem  = 1'b1;
         o_bubble_mem_wb = 1'b1;
         o_pc_hold       = 1'b1;
      end else if (i_ex_mispredict) begin
         o_flush_if_id = 1'b1;
         o_flush_id_ex = 1'b1;
         o_pc_redirect = 1'b1;
      end else if (w_lu) begin
         o_stall_if_id = 1'b1;
         o_flush_id_ex = 1'b1;
         o_pc_hold     = 1'b1;
      end else if (w_eff == ST_DRAIN || (w_eff == ST_RUN && i_id_halt) || !i_if_rdy) begin
         o_flush_if_id = 1'b1;
         o_pc_hold     = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ret_nxt     = r_ret_drain;
      w_wait_nxt    = r_wait;
      w_drain_nxt   = r_drain;
      w_timeout_nxt = r_timeout;
      if (r_state == ST_HALT) begin
         if (i_resume && !r_timeout) w_state_nxt = ST_RUN;
      end else if (r_state == ST_MEM_WAIT && w_mw) begin
         if (r_wait == WAIT_LAST) begin
            w_state_nxt   = ST_HALT;
            w_timeout_nxt = 1'b1;
         end else begin
            w_wait_nxt = r_wait + WAIT_W'(1);
         end
      end else if (w_mw) begin
         w_state_nxt = ST_MEM_WAIT;
         w_ret_nxt   = (w_eff == ST_DRAIN);
         w_wait_nxt  = '0;
      end else if (w_eff == ST_DRAIN) begin
         if (r_drain == DRAIN_LAST) begin
            w_state_nxt = ST_HALT;
         end else begin
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = r_drain + DRAIN_W'(1);
         end
      end else begin
         w_state_nxt = ST_RUN;
         if (i_id_halt && !i_ex_mispredict && !w_lu) begin
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_ret_drain <= 1'b0;
         r_wait      <= '0;
         r_drain     <= '0;
         r_timeout   <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ret_drain <= w_ret_nxt;
         r_wait      <= w_wait_nxt;
         r_drain     <= w_drain_nxt;
         r_timeout   <= w_timeout_nxt;
         if (o_pc_hold && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (o_flush_id_ex && i_ex_mispredict && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign o_halted      = (r_state == ST_HALT);
   assign o_mem_timeout = r_timeout;
   assign o_state       = r_state;
   assign o_stall_cnt   = r_stall_cnt;
   assign o_flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios plus randomized traffic against a
// table-driven behavioural model of the sequencer.
module tb_pipe_ctrl;

   localparam int MEM_TO  = 8;
   localparam int DRAIN   = 3;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;
   localparam int RUN = 0, MW = 1, DR = 2, HL = 3;

   // Control vector order: stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
   // flush_id_ex, bubble_mem_wb, pc_hold, pc_redirect
   localparam logic [7:0] C_IDLE  = 8'h00;
   localparam logic [7:0] C_HOLD  = 8'hE6;
   localparam logic [7:0] C_MISP  = 8'h19;
   localparam logic [7:0] C_LU    = 8'h8A;
   localparam logic [7:0] C_FETCH = 8'h12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    p0_addr, p1_addr, ex_dst;
   logic          p0_used, p1_used, id_halt, ex_we, ex_mem_re, ex_misp;
   logic          if_rdy, mem_access, mem_rdy, resume;
   logic          stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex;
   logic          bubble_mem_wb, pc_hold, pc_redirect, halted, mem_timeout;
   logic [1:0]    state;
   logic [CW-1:0] stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .MEM_TO_CYC(MEM_TO),
      .DRAIN_CYC (DRAIN),
      .CNT_W     (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_id_p0_addr   (p0_addr),
      .i_id_p1_addr   (p1_addr),
      .i_id_p0_used   (p0_used),
      .i_id_p1_used   (p1_used),
      .i_id_halt      (id_halt),
      .i_ex_dst_addr  (ex_dst),
      .i_ex_we        (ex_we),
      .i_ex_mem_re    (ex_mem_re),
      .i_ex_mispredict(ex_misp),
      .i_if_rdy       (if_rdy),
      .i_mem_access   (mem_access),
      .i_mem_rdy      (mem_rdy),
      .i_resume       (resume),
      .o_stall_if_id  (stall_if_id),
      .o_stall_id_ex  (stall_id_ex),
      .o_stall_ex_mem (stall_ex_mem),
      .o_flush_if_id  (flush_if_id),
      .o_flush_id_ex  (flush_id_ex),
      .o_bubble_mem_wb(bubble_mem_wb),
      .o_pc_hold      (pc_hold),
      .o_pc_redirect  (pc_redirect),
      .o_halted       (halted),
      .o_mem_timeout  (mem_timeout),
      .o_state        (state),
      .o_stall_cnt    (stall_cnt),
      .o_flush_cnt    (flush_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: mode, where a memory wait returns to, cycles waited, drain cycles left, counters
   int         m_st, m_ret, m_waited, m_left, m_stall, m_flush;
   bit         m_to;
   logic [7:0] s_ctrl;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic set_idle();
      p0_addr = 4'd0; p1_addr = 4'd0; ex_dst = 4'd0;
      p0_used = 1'b0; p1_used = 1'b0; id_halt = 1'b0; ex_we = 1'b0; ex_mem_re = 1'b0;
      ex_misp = 1'b0; if_rdy = 1'b1; mem_access = 1'b0; mem_rdy = 1'b0; resume = 1'b0;
   endtask

   task automatic model_reset();
      m_st = RUN; m_ret = RUN; m_waited = 0; m_left = 0; m_stall = 0; m_flush = 0; m_to = 1'b0;
   endtask

   // Called at posedge+1 with inputs set; returns at the next posedge+1.
   task automatic do_reset();
      set_idle();
      rst_n = 1'b0;
      #1;
      check("rst_stall_cnt", 32'(stall_cnt), 0);
      check("rst_flush_cnt", 32'(flush_cnt), 0);
      check("rst_status", 32'({halted, mem_timeout, state}), 0);
      model_reset();
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      logic [7:0] e;
      logic [7:0] got;
      logic [3:0] es;
      bit         mw, lu;
      int         act;
      #2;
      mw  = mem_access && !mem_rdy;
      lu  = ex_mem_re && ex_we && (ex_dst != 4'd0) &&
            ((p0_used && p0_addr == ex_dst) || (p1_used && p1_addr == ex_dst));
      act = (m_st == MW && !mw) ? m_ret : m_st;
      if (m_st == HL || mw)                         e = C_HOLD;
      else if (ex_misp)                             e = C_MISP;
      else if (lu)                                  e = C_LU;
      else if (act == DR || (act == RUN && id_halt)) e = C_FETCH;
      else if (!if_rdy)                             e = C_FETCH;
      else                                          e = C_IDLE;
      got = {stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex,
             bubble_mem_wb, pc_hold, pc_redirect};
      s_ctrl = got;
      es = {m_st == HL, m_to, 2'(m_st)};
      check("ctrl", 32'(got), 32'(e));
      check("status", 32'({halted, mem_timeout, state}), 32'(es));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      if (e[1] && m_stall < CNT_MAX) m_stall++;
      if (e == C_MISP && m_flush < CNT_MAX) m_flush++;
      if (m_st == HL) begin
         if (resume && !m_to) m_st = RUN;
      end else if (m_st == MW && mw) begin
         if (m_waited + 1 == MEM_TO) begin
            m_st = HL;
            m_to = 1'b1;
         end else begin
            m_waited++;
         end
      end else if (mw) begin
         m_ret = act; m_st = MW; m_waited = 0;
      end else if (act == DR) begin
         m_left--;
         m_st = (m_left == 0) ? HL : DR;
      end else begin
         m_st = RUN;
         if (id_halt && !ex_misp && !lu) begin
            m_st = DR; m_left = DRAIN;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      set_idle();
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      cycle();
      check("idle_ctrl", 32'(s_ctrl), 32'(C_IDLE));

      // Load-use on p1, then one clear cycle, then a load to r0
      ex_mem_re = 1'b1; ex_we = 1'b1; ex_dst = 4'd3;
      p1_addr = 4'd3; p1_used = 1'b1; p0_addr = 4'd5; p0_used = 1'b1;
      cycle();
      check("lu_ctrl", 32'(s_ctrl), 32'(C_LU));
      set_idle();
      cycle();
      check("lu_one_cycle", 32'(s_ctrl), 32'(C_IDLE));
      ex_mem_re = 1'b1; ex_we = 1'b1; ex_dst = 4'd0; p1_addr = 4'd0; p1_used = 1'b1;
      cycle();
      check("lu_r0_ctrl", 32'(s_ctrl), 32'(C_IDLE));
      check("lu_stall_cnt", 32'(stall_cnt), 1);
      check("model_lu_stall", 32'(m_stall), 1);

      // Mispredict overrides a simultaneous load-use
      ex_dst = 4'd3; p1_addr = 4'd3; ex_misp = 1'b1;
      cycle();
      check("misp_ctrl", 32'(s_ctrl), 32'(C_MISP));
      set_idle();
      check("misp_flush_cnt", 32'(flush_cnt), 1);

      // Five-cycle memory wait
      do_reset();
      mem_access = 1'b1; mem_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("mw_ctrl", 32'(s_ctrl), 32'(C_HOLD));
      end
      check("mw_state", 32'(state), 1);
      mem_rdy = 1'b1;
      cycle();
      check("mw_release_ctrl", 32'(s_ctrl), 32'(C_IDLE));
      set_idle();
      check("mw_back_run", 32'(state), 0);
      check("mw_stall_cnt", 32'(stall_cnt), 5);

      // mem_rdy on the threshold cycle wins over timeout
      do_reset();
      mem_access = 1'b1; mem_rdy = 1'b0;
      repeat (8) cycle();
      mem_rdy = 1'b1;
      cycle();
      set_idle();
      check("thr_state", 32'(state), 0);
      check("thr_timeout", 32'(mem_timeout), 0);

      // Timeout: one RUN cycle plus MEM_TO waited cycles
      do_reset();
      mem_access = 1'b1; mem_rdy = 1'b0;
      repeat (MEM_TO + 1) cycle();
      check("to_state", 32'(state), 3);
      check("to_flag", 32'(mem_timeout), 1);
      check("to_halted", 32'(halted), 1);
      set_idle();
      resume = 1'b1;
      cycle();
      resume = 1'b0;
      check("to_resume_ignored", 32'(state), 3);
      do_reset();

      // HALT decode, drain, resume
      id_halt = 1'b1;
      cycle();
      check("halt_decode_ctrl", 32'(s_ctrl), 32'(C_FETCH));
      id_halt = 1'b0;
      for (int i = 0; i < DRAIN; i++) begin
         cycle();
         check("drain_ctrl", 32'(s_ctrl), 32'(C_FETCH));
      end
      check("halted_after_drain", 32'(halted), 1);
      resume = 1'b1;
      cycle();
      resume = 1'b0;
      check("resume_state", 32'(state), 0);
      cycle();
      check("run_ctrl", 32'(s_ctrl), 32'(C_IDLE));

      // Two-cycle memory wait inside a drain stretches it by two cycles
      id_halt = 1'b1;
      cycle();
      id_halt = 1'b0;
      cycle();
      mem_access = 1'b1; mem_rdy = 1'b0;
      repeat (2) cycle();
      set_idle();
      n = 0;
      while (!halted && n < 10) begin
         cycle();
         n++;
      end
      check("drain_ext_cycles", 32'(n), 2);

      // Counter saturation, then asynchronous reset mid-count
      do_reset();
      if_rdy = 1'b0;
      repeat (20) cycle();
      check("sat_stall_cnt", 32'(stall_cnt), 15);
      check("model_sat", 32'(m_stall), 15);
      mem_access = 1'b1;
      cycle();
      do_reset();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 249) do_reset();
         p0_addr    = 4'($urandom_range(0, 3));
         p1_addr    = 4'($urandom_range(0, 3));
         ex_dst     = 4'($urandom_range(0, 3));
         p0_used    = ($urandom_range(0, 1) == 0);
         p1_used    = ($urandom_range(0, 1) == 0);
         ex_we      = ($urandom_range(0, 1) == 0);
         ex_mem_re  = ($urandom_range(0, 1) == 0);
         ex_misp    = ($urandom_range(0, 7) == 0);
         id_halt    = ($urandom_range(0, 15) == 0);
         if_rdy     = ($urandom_range(0, 7) != 0);
         mem_access = ($urandom_range(0, 3) == 0);
         mem_rdy    = ($urandom_range(0, 1) == 0);
         resume     = ($urandom_range(0, 7) == 0);
         cycle();
      end
      set_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
